program_loader: RTL and testbench
=================================

// Module: program_loader
// PURPOSE
//  Byte-stream bootloader that writes programs into the CPU's program memory.
//  The CPU only reads program memory (addr -> 18-bit instruction); this block is the writer side.
//  It receives a framed byte stream, assembles 18-bit instructions and drives the memory write port.
//  It holds the CPU halted while loading and reports done or an error code.
// PARAMETERS
//  BASE_ADDR  16'h0000  program-memory address of the first loaded word
//  ADDR_W     16        program-memory address width
//  INSTR_W    18        instruction width; fixed at 18, the only supported value
// PORTS
//  i_clock      in   1       system clock; all logic is on the rising edge
//  i_reset      in   1       synchronous, active-high reset
//  i_start      in   1       begin a load; sampled in IDLE, DONE and ERROR only
//  i_byte       in   8       stream byte
//  i_byteValid  in   1       i_byte is valid
//  o_byteReady  out  1       loader accepts i_byte this cycle
//  o_memAddr    out  ADDR_W  program-memory write address
//  o_memData    out  18      program-memory write data
//  o_memWrite   out  1       one-cycle write strobe
//  o_cpuHalt    out  1       CPU must not fetch or advance IP while high
//  o_done       out  1       load completed with a good checksum; level signal
//  o_error      out  2       00 none, 01 pad bits, 10 checksum, 11 length
//  o_wordCount  out  ADDR_W  number of words written so far
// BEHAVIOUR
//  Reset: state=IDLE. All outputs are 0: o_byteReady, o_memWrite, o_cpuHalt, o_done, o_error,
//   o_wordCount, o_memAddr and o_memData. Reset wins over every other input, including mid-load.
//   A partial load is abandoned; words already written are not undone.
//  Transfer: a byte transfers on a clock edge where i_byteValid && o_byteReady.
//   o_byteReady is high only in LEN_HI, LEN_LO, B0, B1, B2 and CSUM. It is combinational from state.
//  Frame: LEN_HI, LEN_LO (N words, big-endian), then N x {B0,B1,B2}, then CSUM.
//   Instruction = {B0[1:0], B1, B2}. B0[7:2] must be 0.
//   Checksum: the 8-bit sum of every frame byte, including header and CSUM, must be 8'h00.
//  FSM:
//   IDLE  : i_start -> LEN_HI; clear count, sum and error; o_cpuHalt<=1; o_done<=0.
//   LEN_HI: on byte -> LEN_LO.
//   LEN_LO: on byte, check the length.
//     If N==0 or N > 2^ADDR_W - BASE_ADDR -> ERROR with code 11.
//     Otherwise -> B0.
//   B0    : on byte, if B0[7:2]!=0 -> ERROR with code 01. Otherwise -> B1.
//   B1    : on byte -> B2.
//   B2    : on byte -> WRITE.
//   WRITE : for exactly one cycle, o_memWrite=1 with o_memAddr=BASE_ADDR+o_wordCount.
//     o_memData is the assembled word.
//     o_wordCount increments at the end of this cycle.
//     -> CSUM if this was word N, else -> B0.
//   CSUM  : on byte, if the running sum is 0 -> DONE, else -> ERROR with code 10.
//   DONE  : o_done=1, o_cpuHalt=0. i_start -> LEN_HI.
//   ERROR : o_cpuHalt stays 1; o_error holds its code. i_start -> LEN_HI with o_error cleared.
//  Latency: the write strobe is in the cycle after the B2 transfer.
//   o_done rises in the cycle after the CSUM transfer.
//  Data outputs: o_memAddr and o_memData are stable during WRITE and may change at other times.
//   o_memWrite is never high outside WRITE.
//  i_start while busy (LEN_HI..CSUM) is ignored. i_byteValid is ignored in IDLE, DONE and ERROR.
//  Address arithmetic is modulo 2^ADDR_W. The length check guarantees no wrap within one load.
// TESTING
//  1. Frame 00 01 02 AB CD 85 -> exactly one write, addr 0000 data 2ABCD.
//     o_done=1 and o_cpuHalt=0 two cycles after the last byte; o_wordCount=1.
//  2. Same frame with CSUM 84 -> one write, then o_error=10, o_cpuHalt=1, o_done=0.
//  3. Frame 00 01 04 .. -> o_error=01 after the B0 byte and no o_memWrite pulse.
//     Length 00 00 -> o_error=11.
//  4. N=3, i_byteValid toggled every other cycle -> writes at addr 0,1,2 in order.
//     Each write is one cycle long and o_byteReady=0 during every WRITE cycle.
//  5. i_reset asserted after the 2nd data word -> all outputs 0 next cycle.
//     A fresh i_start plus a good frame then loads correctly.
//  6. i_start pulsed mid-frame -> no effect. BASE_ADDR=FFFE with N=3 -> o_error=11.

Source files
------------

// File: rtl/program_loader.sv
// Byte-stream bootloader: parses a length-prefixed, checksummed frame of 18-bit
// instructions and writes them into program memory while holding the CPU halted.
//
// state  | meaning
// IDLE   | after reset; CPU runs, waiting for i_start
// LEN_HI | expecting word-count high byte
// LEN_LO | expecting word-count low byte; length is validated here
// B0     | expecting instruction bits [17:16] (upper six bits must be zero)
// B1     | expecting instruction bits [15:8]
// B2     | expecting instruction bits [7:0]
// WRITE  | one-cycle program-memory write strobe
// CSUM   | expecting the checksum byte
// DONE   | load good; CPU released
// ERROR  | load failed; CPU stays halted, o_error holds the cause
module program_loader #(
  parameter int              ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int              INSTR_W   = 18
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [7:0]         i_byte,
  input  logic               i_byteValid,
  output logic               o_byteReady,
  output logic [ADDR_W-1:0]  o_memAddr,
  output logic [INSTR_W-1:0] o_memData,
  output logic               o_memWrite,
  output logic               o_cpuHalt,
  output logic               o_done,
  output logic [1:0]         o_error,
  output logic [ADDR_W-1:0]  o_wordCount
);

  typedef enum logic [3:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_B0, S_B1, S_B2, S_WRITE, S_CSUM, S_DONE, S_ERROR
  } state_t;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_PAD  = 2'b01;
  localparam logic [1:0] ERR_CSUM = 2'b10;
  localparam logic [1:0] ERR_LEN  = 2'b11;

  // Largest legal word count: the words must fit between BASE_ADDR and the top of memory.
  localparam logic [ADDR_W:0] SPAN  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] LIMIT = SPAN - {1'b0, BASE_ADDR};

  state_t              state_q, state_d;
  logic [7:0]          len_hi_q, len_hi_d;
  logic [15:0]         rem_q, rem_d;
  logic [7:0]          sum_q, sum_d;
  logic [1:0]          b0_q, b0_d;
  logic [7:0]          b1_q, b1_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [INSTR_W-1:0]  data_q, data_d;
  logic [ADDR_W-1:0]   count_q, count_d;
  logic                halt_q, halt_d;
  logic                done_q, done_d;
  logic [1:0]          err_q, err_d;

  logic                byte_ready;
  logic                xfer;
  logic [7:0]          sum_add;
  logic [15:0]         len_n;
  logic                len_bad;

  always_comb begin
    byte_ready = 1'b0;
    case (state_q)
      S_LEN_HI, S_LEN_LO, S_B0, S_B1, S_B2, S_CSUM: byte_ready = 1'b1;
      default:                                      byte_ready = 1'b0;
    endcase
  end

  assign xfer    = i_byteValid && byte_ready;
  assign sum_add = sum_q + i_byte;
  assign len_n   = {len_hi_q, i_byte};
  assign len_bad = (len_n == 16'd0) || (33'(len_n) > 33'(LIMIT));

  always_comb begin
    state_d  = state_q;
    len_hi_d = len_hi_q;
    rem_d    = rem_q;
    sum_d    = sum_q;
    b0_d     = b0_q;
    b1_d     = b1_q;
    addr_d   = addr_q;
    data_d   = data_q;
    count_d  = count_q;
    halt_d   = halt_q;
    done_d   = done_q;
    err_d    = err_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (i_start) begin
          state_d = S_LEN_HI;
          count_d = '0;
          sum_d   = 8'h00;
          err_d   = ERR_NONE;
          halt_d  = 1'b1;
          done_d  = 1'b0;
        end
      end
      S_LEN_HI: begin
        if (xfer) begin
          len_hi_d = i_byte;
          sum_d    = sum_add;
          state_d  = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (xfer) begin
          sum_d = sum_add;
          rem_d = len_n;
          if (len_bad) begin
            err_d   = ERR_LEN;
            state_d = S_ERROR;
          end else begin
            state_d = S_B0;
          end
        end
      end
      S_B0: begin
        if (xfer) begin
          sum_d = sum_add;
          b0_d  = i_byte[1:0];
          if (i_byte[7:2] != 6'd0) begin
            err_d   = ERR_PAD;
            state_d = S_ERROR;
          end else begin
            state_d = S_B1;
          end
        end
      end
      S_B1: begin
        if (xfer) begin
          sum_d   = sum_add;
          b1_d    = i_byte;
          state_d = S_B2;
        end
      end
      S_B2: begin
        if (xfer) begin
          sum_d   = sum_add;
          data_d  = {b0_q, b1_q, i_byte};
          addr_d  = BASE_ADDR + count_q;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        count_d = count_q + 1'b1;
        rem_d   = rem_q - 16'd1;
        state_d = (rem_q == 16'd1) ? S_CSUM : S_B0;
      end
      S_CSUM: begin
        if (xfer) begin
          sum_d = sum_add;
          if (sum_add == 8'h00) begin
            done_d  = 1'b1;
            halt_d  = 1'b0;
            state_d = S_DONE;
          end else begin
            err_d   = ERR_CSUM;
            state_d = S_ERROR;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q  <= S_IDLE;
      len_hi_q <= 8'h00;
      rem_q    <= 16'd0;
      sum_q    <= 8'h00;
      b0_q     <= 2'b00;
      b1_q     <= 8'h00;
      addr_q   <= '0;
      data_q   <= '0;
      count_q  <= '0;
      halt_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= ERR_NONE;
    end else begin
      state_q  <= state_d;
      len_hi_q <= len_hi_d;
      rem_q    <= rem_d;
      sum_q    <= sum_d;
      b0_q     <= b0_d;
      b1_q     <= b1_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      count_q  <= count_d;
      halt_q   <= halt_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign o_byteReady = byte_ready;
  assign o_memWrite  = (state_q == S_WRITE);
  assign o_memAddr   = addr_q;
  assign o_memData   = data_q;
  assign o_cpuHalt   = halt_q;
  assign o_done      = done_q;
  assign o_error     = err_q;
  assign o_wordCount = count_q;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: directed and random frames checked against a frame-level
// model; a second instance with BASE_ADDR=FFFE covers the top-of-memory length limit.
module tb_program_loader;
  typedef logic [7:0] bq_t[$];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, bvalid;
  logic [7:0] bdata;
  bit         sel;

  logic        rdy1, wr1, halt1, done1, rdy2, wr2, halt2, done2;
  logic [15:0] addr1, cnt1, addr2, cnt2;
  logic [17:0] data1, data2;
  logic [1:0]  err1, err2;

  program_loader dut (
    .i_clock(clk), .i_reset(rst), .i_start(start & ~sel), .i_byte(bdata),
    .i_byteValid(bvalid & ~sel), .o_byteReady(rdy1), .o_memAddr(addr1),
    .o_memData(data1), .o_memWrite(wr1), .o_cpuHalt(halt1), .o_done(done1),
    .o_error(err1), .o_wordCount(cnt1));

  program_loader #(.BASE_ADDR(16'hFFFE)) dut_top (
    .i_clock(clk), .i_reset(rst), .i_start(start & sel), .i_byte(bdata),
    .i_byteValid(bvalid & sel), .o_byteReady(rdy2), .o_memAddr(addr2),
    .o_memData(data2), .o_memWrite(wr2), .o_cpuHalt(halt2), .o_done(done2),
    .o_error(err2), .o_wordCount(cnt2));

  logic        m_rdy, m_wr, m_halt, m_done;
  logic [15:0] m_addr, m_cnt;
  logic [17:0] m_data;
  logic [1:0]  m_err;
  assign m_rdy  = sel ? rdy2  : rdy1;
  assign m_wr   = sel ? wr2   : wr1;
  assign m_halt = sel ? halt2 : halt1;
  assign m_done = sel ? done2 : done1;
  assign m_addr = sel ? addr2 : addr1;
  assign m_cnt  = sel ? cnt2  : cnt1;
  assign m_data = sel ? data2 : data1;
  assign m_err  = sel ? err2  : err1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Every observed write, plus the one-cycle-strobe and ready-low-during-write rules.
  logic [33:0] wq[$];
  bit          prev_w = 1'b0;
  always @(negedge clk) begin
    if (m_wr) begin
      wq.push_back({m_addr, m_data});
      chk("ready_during_write", m_rdy, 1'b0);
      chk("strobe_one_cycle", prev_w, 1'b0);
    end
    prev_w = m_wr;
  end

  // Frame-level reference: what a loader at base address `base` must do with frame f.
  logic [33:0] exp_w[$];
  int          exp_err, exp_done, exp_consumed;

  task automatic model(input bq_t f, input int base);
    int n, s;
    logic [7:0] b;
    exp_w.delete();
    exp_err  = 0;
    exp_done = 0;
    n = int'(f[0]) * 256 + int'(f[1]);
    if (n == 0 || n > 65536 - base) begin
      exp_err = 3;
      exp_consumed = 2;
      return;
    end
    for (int i = 0; i < n; i++) begin
      b = f[2 + 3*i];
      if (b > 8'd3) begin
        exp_err = 1;
        exp_consumed = 3 + 3*i;
        return;
      end
      exp_w.push_back({16'(base + i), b[1:0], f[3 + 3*i], f[4 + 3*i]});
    end
    s = 0;
    foreach (f[i]) s += int'(f[i]);
    exp_consumed = 3 + 3*n;
    if (s % 256 == 0) exp_done = 1;
    else exp_err = 2;
  endtask

  function automatic bq_t mk(input int n, input bit bad_b0, input bit bad_cs);
    bq_t q;
    int  s, bad_i;
    logic [7:0] cs;
    q = {8'(n >> 8), 8'(n)};
    bad_i = (n > 0) ? int'($urandom_range(0, n - 1)) : 0;
    for (int i = 0; i < n; i++) begin
      if (bad_b0 && i == bad_i) q.push_back(8'($urandom_range(4, 255)));
      else q.push_back(8'($urandom_range(0, 3)));
      q.push_back(8'($urandom));
      q.push_back(8'($urandom));
    end
    s = 0;
    foreach (q[i]) s += int'(q[i]);
    cs = 8'(-s);
    if (bad_cs) cs = cs + 8'($urandom_range(1, 255));
    q.push_back(cs);
    return q;
  endfunction

  // Drives f[0..cnt-1] from a negedge; returns at the negedge after the last transfer.
  task automatic send(input bq_t f, input int cnt, input bit toggle, input bit noise);
    int idx, cyc;
    bit ph;
    idx = 0; cyc = 0; ph = 1'b0;
    while (idx < cnt && cyc < 2000) begin
      start = noise && ($urandom_range(0, 3) == 0);
      if (toggle && ph) begin
        bvalid = 1'b0;
      end else begin
        bvalid = 1'b1;
        bdata  = f[idx];
        if (m_rdy) idx++;
      end
      ph = ~ph;
      cyc++;
      @(negedge clk);
    end
    bvalid = 1'b0;
    start  = 1'b0;
    if (cyc >= 2000) chk("send_timeout", 32'(idx), 32'(cnt));
  endtask

  task automatic kick();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wq.delete();
    chk("halt_on_start", m_halt, 1'b1);
    chk("done_cleared", m_done, 1'b0);
    chk("error_cleared", m_err, 2'b00);
    chk("count_cleared", m_cnt, 16'd0);
  endtask

  task automatic run_frame(input string tag, input bq_t f, input int base,
                           input bit toggle, input bit noise);
    model(f, base);
    kick();
    send(f, exp_consumed, toggle, noise);
    chk({tag, "_done_latency"}, m_done, 32'(exp_done));
    chk({tag, "_err_latency"}, m_err, 32'(exp_err));
    repeat (2) @(negedge clk);
    chk({tag, "_done"}, m_done, 32'(exp_done));
    chk({tag, "_err"}, m_err, 32'(exp_err));
    chk({tag, "_halt"}, m_halt, 32'(exp_done == 0));
    chk({tag, "_ready_idle"}, m_rdy, 1'b0);
    chk({tag, "_count"}, m_cnt, 32'(exp_w.size()));
    chk({tag, "_nwrites"}, 32'(wq.size()), 32'(exp_w.size()));
    for (int i = 0; i < wq.size() && i < exp_w.size(); i++) begin
      chk({tag, "_addr"}, 32'(wq[i][33:18]), 32'(exp_w[i][33:18]));
      chk({tag, "_data"}, 32'(wq[i][17:0]), 32'(exp_w[i][17:0]));
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_rdy"}, m_rdy, 1'b0);
    chk({tag, "_wr"}, m_wr, 1'b0);
    chk({tag, "_halt"}, m_halt, 1'b0);
    chk({tag, "_done"}, m_done, 1'b0);
    chk({tag, "_err"}, m_err, 2'b00);
    chk({tag, "_cnt"}, m_cnt, 16'd0);
    chk({tag, "_addr"}, m_addr, 16'd0);
    chk({tag, "_data"}, m_data, 18'd0);
  endtask

  initial begin
    bq_t f;
    logic [33:0] w0;
    rst = 1'b1; start = 1'b0; bvalid = 1'b0; bdata = 8'h00; sel = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset_a");
    sel = 1'b1;
    check_all_zero("reset_b");
    sel = 1'b0;
    rst = 1'b0;

    f = {8'h00, 8'h01, 8'h02, 8'hAB, 8'hCD, 8'h85};
    run_frame("single_word", f, 0, 1'b0, 1'b0);
    w0 = (wq.size() > 0) ? wq[0] : 34'd0;
    chk("single_word_literal", 32'(w0[17:0]), 32'h2ABCD);

    f = {8'h00, 8'h01, 8'h02, 8'hAB, 8'hCD, 8'h84};
    run_frame("bad_csum", f, 0, 1'b0, 1'b0);
    chk("bad_csum_code", m_err, 2'b10);

    f = {8'h00, 8'h01, 8'h04, 8'h00, 8'h00, 8'h00};
    run_frame("pad_bits", f, 0, 1'b0, 1'b0);
    chk("pad_bits_code", m_err, 2'b01);

    f = {8'h00, 8'h00, 8'h00};
    run_frame("zero_len", f, 0, 1'b0, 1'b0);
    chk("zero_len_code", m_err, 2'b11);

    run_frame("toggle_n3", mk(3, 1'b0, 1'b0), 0, 1'b1, 1'b0);

    // Reset in the middle of a load, after the second word has been written.
    f = mk(3, 1'b0, 1'b0);
    kick();
    send(f, 8, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    chk("pre_reset_writes", 32'(wq.size()), 32'd2);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("mid_reset");
    rst = 1'b0;
    run_frame("after_reset", mk(3, 1'b0, 1'b0), 0, 1'b0, 1'b0);

    run_frame("start_noise", mk(4, 1'b0, 1'b0), 0, 1'b0, 1'b1);

    sel = 1'b1;
    f = {8'h00, 8'h03, 8'h00};
    run_frame("top_len3", f, 16'hFFFE, 1'b0, 1'b0);
    chk("top_len3_code", m_err, 2'b11);
    run_frame("top_len2", mk(2, 1'b0, 1'b0), 16'hFFFE, 1'b1, 1'b0);
    sel = 1'b0;

    for (int k = 0; k < 30; k++) begin
      int  n;
      bit  bb, bc;
      n  = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 8));
      bb = ($urandom_range(0, 4) == 0);
      bc = ($urandom_range(0, 4) == 0);
      run_frame("random", mk(n, bb, bc), 0, 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
